// File: rtl/cdc_bus_capture_if.sv
// Stream-side bundle for cdc_bus_capture: capture pulse and bus in, valid/ready stream,
// credit, overflow and fill status out. The producer/consumer side uses master, the block uses slave.
interface cdc_bus_capture_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              sync_valid;
   logic [DATA_W-1:0] bus_in;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;
   logic              credit_ret;
   logic              overflow;
   logic              ovf_clr;
   logic [CW-1:0]     fill;

   modport master (
      output sync_valid, bus_in, m_ready, ovf_clr,
      input  m_valid, m_data, credit_ret, overflow, fill
   );

   modport slave (
      input  sync_valid, bus_in, m_ready, ovf_clr,
      output m_valid, m_data, credit_ret, overflow, fill
   );
endinterface

// File: rtl/cdc_bus_capture.sv
// Destination-domain capture of a source-held bus on a synchronized valid pulse,
// buffered in a small register FIFO and returned as a valid/ready stream with per-pop credits.
module cdc_bus_capture #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   cdc_bus_capture_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_fill;
   logic              r_credit;
   logic              r_overflow;

   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_full = (r_fill == FULL_CNT);
   assign w_pop  = (r_fill != '0) & bus.m_ready;
   // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
   assign w_push = bus.sync_valid & (~w_full | w_pop);
   assign w_drop = bus.sync_valid & w_full & ~w_pop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= bus.bus_in;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_credit   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + CW'(1);
            2'b01:   r_fill <= r_fill - CW'(1);
            default: r_fill <= r_fill;
         endcase
         r_credit <= w_pop;
         // A new overflow in the same cycle as a clear keeps the flag set.
         if (w_drop)           r_overflow <= 1'b1;
         else if (bus.ovf_clr) r_overflow <= 1'b0;
      end
   end

   assign bus.m_valid    = (r_fill != '0);
   assign bus.m_data     = r_mem[r_rd_ptr];
   assign bus.credit_ret = r_credit;
   assign bus.overflow   = r_overflow;
   assign bus.fill       = r_fill;
endmodule
